pipeline_hold_ctrl: RTL and testbench
=====================================

Name: pipeline_hold_ctrl

Overview:
- Central hold/flush sequencer for the 5-stage pipeline.
- Arbitrates stall and redirect requests from Id, Ex and the fetch/memory interfaces.
- Drives per-stage hold and flush flags to the Pc, If2Id, Id2Ex and Ex2Mem buffer registers, plus a registered redirect target to Pc.
- A small FSM guarantees multi-cycle stalls and branch-flush bubbles have deterministic lengths.

Parameters:
- ADDR_W, 64, width of instruction address / jump target.
- FLUSH_CYCLES, 2, number of cycles the front-end flush persists after a redirect (1..7).
- STAGES, 4, number of controlled stage registers (bit0 Pc, bit1 If2Id, bit2 Id2Ex, bit3 Ex2Mem).

Ports:
- Clk  in  1  system clock.
- Rst  in  1  asynchronous active-low reset.
- JumpReqEx  in  1  Ex resolved a taken branch/jump this cycle.
- JumpAddrEx  in  ADDR_W  redirect target from Ex.
- LoadUseId  in  1  Id detected load-use hazard on current instruction.
- ExBusy  in  1  multi-cycle Ex op (mul/div) in progress.
- FetchWait  in  1  instruction memory not ready.
- MemWait  in  1  data memory not ready (Mem stage).
- HoldFlag  out  STAGES  per-stage hold (register keeps value).
- FlushFlag  out  STAGES  per-stage clear (register loads bubble).
- JumpEnOut  out  1  Pc redirect strobe.
- JumpAddrOut  out  ADDR_W  Pc redirect target.
- StateOut  out  2  current FSM state, debug.

Behaviour:
- Reset (Rst=0, async): state=RUN, HoldFlag=0, FlushFlag=0, JumpEnOut=0, JumpAddrOut=0, flush counter=0.
- FSM states: RUN(0), FLUSH(1), STALL_EX(2), STALL_MEM(3).
- Priority, highest first: MemWait > JumpReqEx > ExBusy > LoadUseId > FetchWait.
- MemWait=1, any state:
  - next state STALL_MEM.
  - HoldFlag=4'b1111 combinationally that cycle, FlushFlag=0.
  - Pending flush counter frozen.
  - Return to the previous state class when MemWait drops; the counter resumes.
- JumpReqEx=1 in RUN or STALL_EX (MemWait=0):
  - JumpEnOut=1 and JumpAddrOut=JumpAddrEx for exactly one cycle (combinational, latched into JumpAddrOut register).
  - FlushFlag=4'b0110 (If2Id, Id2Ex) that cycle.
  - Next state FLUSH, counter=FLUSH_CYCLES-1.
- FLUSH:
  - FlushFlag[1]=1 each cycle, counter decrements.
  - Exit to RUN when counter==0 in that cycle.
  - A new JumpReqEx in FLUSH is ignored, since Ex holds a bubble.
  - FLUSH_CYCLES=1 means no FLUSH state is entered.
- ExBusy=1 in RUN:
  - next state STALL_EX, HoldFlag=4'b0111, FlushFlag[3]=1 (bubble into Ex2Mem).
  - Stay while ExBusy.
  - ExBusy falling returns to RUN with no extra cycle.
- LoadUseId=1 in RUN (no higher request):
  - single-cycle stall: HoldFlag=4'b0011, FlushFlag[2]=1.
  - State remains RUN; held stage re-evaluates next cycle.
- FetchWait=1 in RUN: HoldFlag[0]=1, FlushFlag[1]=1; state RUN.
- Simultaneous events:
  - JumpReqEx with LoadUseId: jump wins, no stall.
  - JumpReqEx with ExBusy: impossible by construction; treat jump as winning.
- HoldFlag and FlushFlag bits are never both 1 for the same stage; flush wins.
- All outputs except JumpAddrOut are decoded combinationally from state plus inputs.
- JumpAddrOut is registered: it holds its last value, and updates only on an accepted jump.

Optional Feature:
- Macro HOLD_PERF_CNT_EN.
- When defined:
  - adds 32-bit saturating counters StallCycles (any HoldFlag!=0) and FlushEvents (accepted jumps), exported as outputs StallCntOut and FlushCntOut.
  - Counters clear on reset and saturate at 32'hFFFF_FFFF.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared defines: STATE_* encodings, stage-bit indices (HOLD_PC, HOLD_IF2ID, HOLD_ID2EX, HOLD_EX2MEM), HoldFlagBus width.
- Sub-module pipeline_flush_counter: down-counter with load, freeze and zero flag, used by the FLUSH state.

Test Plan:
- Reset mid-FLUSH (counter=1, Rst low 1 cycle) -> all outputs 0, state RUN next edge.
- RUN, JumpReqEx=1, JumpAddrEx=64'h8000_0040, FLUSH_CYCLES=2:
  - cycle0: JumpEnOut=1, FlushFlag=0110, JumpAddrOut=64'h8000_0040.
  - cycle1: FlushFlag=0010.
  - cycle2: RUN.
- ExBusy high 5 cycles -> HoldFlag=0111 and FlushFlag=1000 for exactly 5 cycles, then RUN with flags 0.
- LoadUseId and JumpReqEx same cycle -> JumpEnOut=1, HoldFlag=0, FlushFlag=0110.
- MemWait asserted 3 cycles during FLUSH (counter=1) -> HoldFlag=1111 for 3 cycles; afterwards exactly one FLUSH cycle, then RUN.
- FetchWait=1 with LoadUseId=1 -> HoldFlag=0011, FlushFlag=0100.

Source files
------------

// File: rtl/pipeline_hold_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_hold_ctrl_pkg
// Shared definitions for the pipeline hold/flush sequencer:
//   - ctrlState_t   : FSM state encodings (RUN, FLUSH, STALL_EX, STALL_MEM)
//   - HOLD_*        : bit positions of each controlled stage register in the
//                     HoldFlag / FlushFlag buses
//   - HOLD_BUS_W    : natural width of the hold/flush buses
//   - satInc32      : saturating increment used by the optional perf counters
// Optional feature macro used by the top: HOLD_PERF_CNT_EN
// ---------------------------------------------------------------------------
package pipeline_hold_ctrl_pkg;

    typedef enum logic [1:0] {
        STATE_RUN       = 2'd0,
        STATE_FLUSH     = 2'd1,
        STATE_STALL_EX  = 2'd2,
        STATE_STALL_MEM = 2'd3
    } ctrlState_t;

    localparam int HOLD_PC     = 0;
    localparam int HOLD_IF2ID  = 1;
    localparam int HOLD_ID2EX  = 2;
    localparam int HOLD_EX2MEM = 3;

    localparam int HOLD_BUS_W  = 4;

    // Wide enough for the largest legal flush length (7)
    localparam int FLUSH_CNT_W = 3;

    localparam int PERF_CNT_W  = 32;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [PERF_CNT_W-1:0] satInc32(input logic [PERF_CNT_W-1:0] value);
        if (value == {PERF_CNT_W{1'b1}}) begin
            return value;
        end
        return value + 1'b1;
    endfunction

endpackage

// File: rtl/pipeline_hold_ctrl_flush.sv
// ---------------------------------------------------------------------------
// pipeline_flush_counter
// Down-counter that times the front-end flush bubble after a redirect.
// Ports:
//   Clk        in   system clock
//   Rst        in   asynchronous active-low reset (count clears to 0)
//   load       in   load loadValue this cycle (takes priority)
//   loadValue  in   value loaded on a redirect
//   dec        in   decrement request (ignored at zero)
//   freeze     in   hold the count regardless of dec
//   zero       out  count == 0
//   lastCycle  out  count == 1, i.e. this decrement reaches zero
// ---------------------------------------------------------------------------
module pipeline_flush_counter #(
    parameter int WIDTH = 3
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    input  logic             dec,
    input  logic             freeze,
    output logic             zero,
    output logic             lastCycle
);

    logic [WIDTH-1:0] count;

    // Load beats decrement; a frozen counter keeps its value while a data
    // memory stall is in progress so the flush resumes where it left off.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (dec && !freeze && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero      = (count == '0);
    assign lastCycle = (count == WIDTH'(1));

endmodule

// File: rtl/pipeline_hold_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hold_ctrl
// Central hold/flush sequencer for the 5-stage pipeline. Arbitrates stall and
// redirect requests (MemWait > JumpReqEx > ExBusy > LoadUseId > FetchWait)
// and drives per-stage hold/flush flags to the Pc, If2Id, Id2Ex and Ex2Mem
// buffer registers, plus a registered redirect target for Pc.
// Ports:
//   Clk          in   system clock
//   Rst          in   asynchronous active-low reset
//   JumpReqEx    in   Ex resolved a taken branch/jump
//   JumpAddrEx   in   redirect target from Ex
//   LoadUseId    in   Id load-use hazard
//   ExBusy       in   multi-cycle Ex operation in progress
//   FetchWait    in   instruction memory not ready
//   MemWait      in   data memory not ready
//   HoldFlag     out  per-stage hold (bit0 Pc .. bit3 Ex2Mem)
//   FlushFlag    out  per-stage bubble insert
//   JumpEnOut    out  Pc redirect strobe
//   JumpAddrOut  out  registered Pc redirect target
//   StateOut     out  current FSM state (debug)
//   StallCntOut  out  saturating stall-cycle count  (HOLD_PERF_CNT_EN only)
//   FlushCntOut  out  saturating accepted-jump count (HOLD_PERF_CNT_EN only)
// Optional feature macro: HOLD_PERF_CNT_EN
// ---------------------------------------------------------------------------
module pipeline_hold_ctrl
    import pipeline_hold_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int FLUSH_CYCLES = 2,
    parameter int STAGES       = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              JumpReqEx,
    input  logic [ADDR_W-1:0] JumpAddrEx,
    input  logic              LoadUseId,
    input  logic              ExBusy,
    input  logic              FetchWait,
    input  logic              MemWait,
    output logic [STAGES-1:0] HoldFlag,
    output logic [STAGES-1:0] FlushFlag,
    output logic              JumpEnOut,
    output logic [ADDR_W-1:0] JumpAddrOut,
    output logic [1:0]        StateOut
`ifdef HOLD_PERF_CNT_EN
   ,output logic [PERF_CNT_W-1:0] StallCntOut,
    output logic [PERF_CNT_W-1:0] FlushCntOut
`endif
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    ctrlState_t state;
    ctrlState_t stateNext;
    ctrlState_t savedState;
    ctrlState_t effState;

    logic [STAGES-1:0] holdRaw;
    logic [STAGES-1:0] flushRaw;
    logic              jumpAccept;
    logic              cntDec;
    logic              cntZero;
    logic              cntLast;

    // While parked in STALL_MEM the controller behaves as the state class it
    // was interrupted in, so the cycle MemWait drops already does useful work
    // (no dead cycle between the memory stall and the resumed flush/stall).
    assign effState = (state == STATE_STALL_MEM) ? savedState : state;

    // State register plus the remembered class to resume after a memory stall.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= STATE_RUN;
            savedState <= STATE_RUN;
        end else begin
            state <= stateNext;
            if (MemWait) begin
                savedState <= effState;
            end
        end
    end

    // Priority decode of requests into next state and per-stage flags.
    // STALL_EX with ExBusy low decodes exactly like RUN, which is what makes
    // the return from a multi-cycle Ex op cost no extra cycle. A jump seen in
    // FLUSH is dropped because Ex only holds a bubble there.
    always_comb begin
        stateNext  = state;
        holdRaw    = '0;
        flushRaw   = '0;
        jumpAccept = 1'b0;
        cntDec     = 1'b0;
        if (MemWait) begin
            stateNext = STATE_STALL_MEM;
            holdRaw   = '1;
        end else begin
            case (effState)
                STATE_FLUSH: begin
                    flushRaw[HOLD_IF2ID] = 1'b1;
                    cntDec               = 1'b1;
                    stateNext            = (cntLast || cntZero) ? STATE_RUN : STATE_FLUSH;
                end
                default: begin
                    if (JumpReqEx) begin
                        jumpAccept           = 1'b1;
                        flushRaw[HOLD_IF2ID] = 1'b1;
                        flushRaw[HOLD_ID2EX] = 1'b1;
                        stateNext            = (FLUSH_CYCLES > 1) ? STATE_FLUSH : STATE_RUN;
                    end else if (ExBusy) begin
                        holdRaw[HOLD_PC]      = 1'b1;
                        holdRaw[HOLD_IF2ID]   = 1'b1;
                        holdRaw[HOLD_ID2EX]   = 1'b1;
                        flushRaw[HOLD_EX2MEM] = 1'b1;
                        stateNext             = STATE_STALL_EX;
                    end else if (LoadUseId) begin
                        holdRaw[HOLD_PC]     = 1'b1;
                        holdRaw[HOLD_IF2ID]  = 1'b1;
                        flushRaw[HOLD_ID2EX] = 1'b1;
                        stateNext            = STATE_RUN;
                    end else if (FetchWait) begin
                        holdRaw[HOLD_PC]     = 1'b1;
                        flushRaw[HOLD_IF2ID] = 1'b1;
                        stateNext            = STATE_RUN;
                    end else begin
                        stateNext = STATE_RUN;
                    end
                end
            endcase
        end
    end

    // A stage that is both held and flushed must take the bubble.
    assign HoldFlag  = holdRaw & ~flushRaw;
    assign FlushFlag = flushRaw;
    assign JumpEnOut = jumpAccept;
    assign StateOut  = state;

    // Redirect target only moves on an accepted jump.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            JumpAddrOut <= '0;
        end else if (jumpAccept) begin
            JumpAddrOut <= JumpAddrEx;
        end
    end

    pipeline_flush_counter #(
        .WIDTH(FLUSH_CNT_W)
    ) flushCounter (
        .Clk      (Clk),
        .Rst      (Rst),
        .load     (jumpAccept),
        .loadValue(FLUSH_LOAD),
        .dec      (cntDec),
        .freeze   (MemWait),
        .zero     (cntZero),
        .lastCycle(cntLast)
    );

`ifdef HOLD_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] stallCnt;
    logic [PERF_CNT_W-1:0] flushCnt;

    // Saturating event counters: any held stage counts as a stall cycle,
    // every accepted redirect counts as a flush event.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (|HoldFlag) begin
                stallCnt <= satInc32(stallCnt);
            end
            if (jumpAccept) begin
                flushCnt <= satInc32(flushCnt);
            end
        end
    end

    assign StallCntOut = stallCnt;
    assign FlushCntOut = flushCnt;
`endif

endmodule

// File: tb/tb_pipeline_hold_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hold_ctrl
// Directed bench for pipeline_hold_ctrl. A cycle-level model of the request
// arbitration (mode, remaining flush cycles, memory-stall flag, last target)
// predicts every output each cycle; literal checks pin the key scenarios.
// ---------------------------------------------------------------------------
module tb_pipeline_hold_ctrl;

    localparam int ADDR_W       = 64;
    localparam int FLUSH_CYCLES = 2;
    localparam int STAGES       = 4;

    logic              Clk = 1'b0;
    logic              Rst = 1'b0;
    logic              JumpReqEx = 1'b0;
    logic [ADDR_W-1:0] JumpAddrEx = '0;
    logic              LoadUseId = 1'b0;
    logic              ExBusy = 1'b0;
    logic              FetchWait = 1'b0;
    logic              MemWait = 1'b0;
    logic [STAGES-1:0] HoldFlag;
    logic [STAGES-1:0] FlushFlag;
    logic              JumpEnOut;
    logic [ADDR_W-1:0] JumpAddrOut;
    logic [1:0]        StateOut;
`ifdef HOLD_PERF_CNT_EN
    logic [31:0]       StallCntOut;
    logic [31:0]       FlushCntOut;
`endif

    int vecCount = 0;
    int errCount = 0;

    // Model: 0 = running, 1 = flushing, 2 = Ex stalled
    int                mMode = 0;
    int                mFlushLeft = 0;
    bit                mMemStalled = 1'b0;
    logic [ADDR_W-1:0] mAddr = '0;

    pipeline_hold_ctrl #(
        .ADDR_W      (ADDR_W),
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .STAGES      (STAGES)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .JumpReqEx  (JumpReqEx),
        .JumpAddrEx (JumpAddrEx),
        .LoadUseId  (LoadUseId),
        .ExBusy     (ExBusy),
        .FetchWait  (FetchWait),
        .MemWait    (MemWait),
        .HoldFlag   (HoldFlag),
        .FlushFlag  (FlushFlag),
        .JumpEnOut  (JumpEnOut),
        .JumpAddrOut(JumpAddrOut),
        .StateOut   (StateOut)
`ifdef HOLD_PERF_CNT_EN
       ,.StallCntOut(StallCntOut),
        .FlushCntOut(FlushCntOut)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        vecCount++;
        if (actual !== required) begin
            errCount++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, required, $time);
        end
    endtask

    task automatic applyStimulus(input logic jr, input logic [ADDR_W-1:0] addr, input logic lu,
                                 input logic eb, input logic fw, input logic mw);
        JumpReqEx  = jr;
        JumpAddrEx = addr;
        LoadUseId  = lu;
        ExBusy     = eb;
        FetchWait  = fw;
        MemWait    = mw;
        #2;
    endtask

    task automatic stepClock;
        @(posedge Clk);
        #1;
    endtask

    // Model state advance on each edge, following the arbitration rules.
    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            mMode       <= 0;
            mFlushLeft  <= 0;
            mMemStalled <= 1'b0;
            mAddr       <= '0;
        end else if (MemWait) begin
            mMemStalled <= 1'b1;
        end else begin
            mMemStalled <= 1'b0;
            if (mMode == 1) begin
                mFlushLeft <= mFlushLeft - 1;
                if (mFlushLeft <= 1) mMode <= 0;
            end else if (JumpReqEx) begin
                mAddr      <= JumpAddrEx;
                mFlushLeft <= FLUSH_CYCLES - 1;
                mMode      <= (FLUSH_CYCLES > 1) ? 1 : 0;
            end else if (ExBusy) begin
                mMode <= 2;
            end else begin
                mMode <= 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge Clk) begin : cmpProc
        logic [3:0] eh;
        logic [3:0] ef;
        logic       ej;
        logic [1:0] es;
        eh = 4'b0000;
        ef = 4'b0000;
        ej = 1'b0;
        if (MemWait)            eh = 4'b1111;
        else if (mMode == 1)    ef = 4'b0010;
        else if (JumpReqEx)     begin ej = 1'b1; ef = 4'b0110; end
        else if (ExBusy)        begin eh = 4'b0111; ef = 4'b1000; end
        else if (LoadUseId)     begin eh = 4'b0011; ef = 4'b0100; end
        else if (FetchWait)     begin eh = 4'b0001; ef = 4'b0010; end
        es = mMemStalled ? 2'd3 : 2'(mMode);
        checkOutput("HoldFlag",    64'(HoldFlag),  64'(eh));
        checkOutput("FlushFlag",   64'(FlushFlag), 64'(ef));
        checkOutput("JumpEnOut",   64'(JumpEnOut), 64'(ej));
        checkOutput("JumpAddrOut", JumpAddrOut,    mAddr);
        checkOutput("StateOut",    64'(StateOut),  64'(es));
    end

    initial begin
        // Reset
        repeat (2) @(posedge Clk);
        #1;
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rstHold",  64'(HoldFlag),  64'h0);
        checkOutput("rstFlush", 64'(FlushFlag), 64'h0);
        checkOutput("rstJen",   64'(JumpEnOut), 64'h0);
        checkOutput("rstAddr",  JumpAddrOut,    64'h0);
        checkOutput("rstState", 64'(StateOut),  64'h0);
        Rst = 1'b1;
        stepClock();

        // Jump from RUN, two-cycle flush
        applyStimulus(1'b1, 64'h8000_0040, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("jmpJen",   64'(JumpEnOut), 64'h1);
        checkOutput("jmpFlush", 64'(FlushFlag), 64'b0110);
        checkOutput("jmpHold",  64'(HoldFlag),  64'h0);
        stepClock();
        checkOutput("jmpAddr",  JumpAddrOut,    64'h8000_0040);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("jmpFlush1", 64'(FlushFlag), 64'b0010);
        checkOutput("jmpState1", 64'(StateOut),  64'h1);
        stepClock();
        checkOutput("jmpState2", 64'(StateOut),  64'h0);

        // ExBusy for five cycles
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
            checkOutput("exHold",  64'(HoldFlag),  64'b0111);
            checkOutput("exFlush", 64'(FlushFlag), 64'b1000);
            stepClock();
        end
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("exEndHold",  64'(HoldFlag),  64'h0);
        checkOutput("exEndFlush", 64'(FlushFlag), 64'h0);
        stepClock();
        checkOutput("exEndState", 64'(StateOut), 64'h0);

        // Jump together with load-use: jump wins
        applyStimulus(1'b1, 64'h0000_1234, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("luJen",   64'(JumpEnOut), 64'h1);
        checkOutput("luHold",  64'(HoldFlag),  64'h0);
        checkOutput("luFlush", 64'(FlushFlag), 64'b0110);
        stepClock();
        // Second jump inside FLUSH is ignored
        applyStimulus(1'b1, 64'hDEAD_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("flJen",   64'(JumpEnOut), 64'h0);
        checkOutput("flFlush", 64'(FlushFlag), 64'b0010);
        stepClock();
        checkOutput("flAddr",  JumpAddrOut,    64'h0000_1234);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepClock();

        // MemWait three cycles during FLUSH
        applyStimulus(1'b1, 64'h0000_2000, 1'b0, 1'b0, 1'b0, 1'b0);
        stepClock();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput("mwHold",  64'(HoldFlag),  64'b1111);
            checkOutput("mwFlush", 64'(FlushFlag), 64'h0);
            stepClock();
        end
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("mwResumeFlush", 64'(FlushFlag), 64'b0010);
        checkOutput("mwResumeState", 64'(StateOut),  64'h3);
        stepClock();
        checkOutput("mwEndFlush", 64'(FlushFlag), 64'h0);
        checkOutput("mwEndState", 64'(StateOut),  64'h0);

        // FetchWait with load-use, then FetchWait alone
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("fwLuHold",  64'(HoldFlag),  64'b0011);
        checkOutput("fwLuFlush", 64'(FlushFlag), 64'b0100);
        stepClock();
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("fwHold",  64'(HoldFlag),  64'b0001);
        checkOutput("fwFlush", 64'(FlushFlag), 64'b0010);
        stepClock();

        // MemWait interrupting an Ex stall, then resume it
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("mwExHold", 64'(HoldFlag), 64'b1111);
        stepClock();
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("exResHold",  64'(HoldFlag),  64'b0111);
        checkOutput("exResFlush", 64'(FlushFlag), 64'b1000);
        stepClock();
        // Jump accepted from STALL_EX
        applyStimulus(1'b1, 64'h0000_3000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("exJmpJen", 64'(JumpEnOut), 64'h1);
        stepClock();

        // Reset mid-FLUSH
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        Rst = 1'b0;
        #2;
        checkOutput("midRstFlush", 64'(FlushFlag), 64'h0);
        checkOutput("midRstHold",  64'(HoldFlag),  64'h0);
        checkOutput("midRstAddr",  JumpAddrOut,    64'h0);
        checkOutput("midRstState", 64'(StateOut),  64'h0);
        stepClock();
        Rst = 1'b1;
        stepClock();
        checkOutput("postRstState", 64'(StateOut), 64'h0);
        stepClock();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
